// File: rtl/wb_trace_fifo_pkg.sv
// Shared pipeline types: the exception bus and the write-back trace entry.
package wb_trace_fifo_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic            valid;
    logic [4:0]      code;
    logic [XLEN-1:0] badvaddr;
  } except_bus;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              wen;
    logic [REG_AW-1:0] wnum;
    logic [XLEN-1:0]   wdata;
  } trace_entry_t;

  // A write to r0 is architecturally invisible, so it is traced with wen cleared.
  function automatic trace_entry_t make_entry(input logic [XLEN-1:0]   pc,
                                              input logic              reg_wen,
                                              input logic [REG_AW-1:0] waddr,
                                              input logic [XLEN-1:0]   wdata);
    trace_entry_t e;
    e.pc    = pc;
    e.wen   = reg_wen && (waddr != '0);
    e.wnum  = waddr;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

// File: rtl/wb_trace_fifo_fifo_2w1r.sv
// Circular buffer accepting up to two writes and one read per cycle.
// Port 1 is only ever written together with port 0 and lands one slot behind it.
module fifo_2w1r
  import wb_trace_fifo_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en0,
  input  entry_t                   wr_data0,
  input  logic                     wr_en1,
  input  entry_t                   wr_data1,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rd_data = mem[rptr];

  // Storage writes: first entry at wptr, second at wptr+1 (pointer width wraps mod DEPTH).
  // NOTE: storage has no reset; stale contents are unreachable because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wptr] <= wr_data0;
    if (wr_en1) mem[wptr + AW'(1)] <= wr_data1;
  end

  // Pointer and occupancy update; caller guarantees count never exceeds DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_en0) + AW'(wr_en1);
      rptr  <= rptr + AW'(rd_en);
      count <= count + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: queues retiring master/slave instructions and emits
// one registered trace record per cycle, stalling mem_wb when nearly full.
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        W_master_valid,
  input  logic        W_slave_valid,
  input  logic        W_master_reg_wen,
  input  logic        W_slave_reg_wen,
  input  logic [4:0]  W_master_reg_waddr,
  input  logic [4:0]  W_slave_reg_waddr,
  input  logic [31:0] W_master_pc,
  input  logic [31:0] W_slave_pc,
  input  logic [31:0] W_master_reg_wdata,
  input  logic [31:0] W_slave_reg_wdata,
  output logic        stall_req,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 2);

  logic [CW-1:0] fifo_count;
  logic          wr_en0;
  logic          wr_en1;
  trace_entry_t  wr_data0;
  trace_entry_t  wr_data1;
  trace_entry_t  head;
  logic          pop;

  // Fewer than two free slots: hold the pipeline. Registered count only, so no input path.
  assign stall_req = (fifo_count > STALL_LVL);
  assign pop       = (fifo_count != '0);

  // Pack the retiring pair into write ports, master first; a lone slave takes port 0.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_data0 = make_entry(W_slave_pc, W_slave_reg_wen, W_slave_reg_waddr, W_slave_reg_wdata);
    wr_data1 = wr_data0;
    if (!stall_req) begin
      if (W_master_valid) begin
        wr_en0   = 1'b1;
        wr_en1   = W_slave_valid;
        wr_data0 = make_entry(W_master_pc, W_master_reg_wen, W_master_reg_waddr,
                              W_master_reg_wdata);
      end else begin
        wr_en0 = W_slave_valid;
      end
    end
  end

  fifo_2w1r #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en0   (wr_en0),
    .wr_data0 (wr_data0),
    .wr_en1   (wr_en1),
    .wr_data1 (wr_data1),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (fifo_count)
  );

  // Trace output register: head entry on a pop, all zeros otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (pop) begin
      debug_wb_pc       <= head.pc;
      debug_wb_rf_wen   <= {4{head.wen}};
      debug_wb_rf_wnum  <= head.wnum;
      debug_wb_rf_wdata <= head.wdata;
    end else begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end
  end

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; legal values are powers of two, minimum 4.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have ports W_master_valid and W_slave_valid, input, 1 bit each: the retiring master or slave instruction is presented this cycle.
REQ-006 SHALL have ports W_master_reg_wen and W_slave_reg_wen, input, 1 bit each: register write enable.
REQ-007 SHALL have ports W_master_reg_waddr and W_slave_reg_waddr, input, 5 bits each: destination register.
REQ-008 SHALL have ports W_master_pc and W_slave_pc, input, 32 bits each: instruction PC.
REQ-009 SHALL have ports W_master_reg_wdata and W_slave_reg_wdata, input, 32 bits each: write data.
REQ-010 SHALL have port stall_req, output, 1 bit: holds mem_wb and the stages upstream of it.
REQ-011 SHALL have port debug_wb_pc, output, 32 bits: traced PC.
REQ-012 SHALL have port debug_wb_rf_wen, output, 4 bits: traced byte write enables.
REQ-013 SHALL have port debug_wb_rf_wnum, output, 5 bits: traced register number.
REQ-014 SHALL have port debug_wb_rf_wdata, output, 32 bits: traced write data.

Function
REQ-015 SHALL define entry = {pc[31:0], wen, wnum[4:0], wdata[31:0]}, where wen = reg_wen AND (waddr != 0).
REQ-016 SHALL drive stall_req = (count > DEPTH-2), i.e. fewer than 2 free slots; stall_req is a function of registered count only, with no combinational path from inputs.
REQ-017 SHALL, when stall_req=0, push the master entry if W_master_valid and the slave entry if W_slave_valid in the same cycle, with master ahead of slave.
REQ-018 SHALL, when only W_slave_valid=1, push the slave entry alone, into the first free slot.
REQ-019 SHALL, when stall_req=1, push nothing; the held mem_wb outputs are re-presented and pushed in the first cycle with stall_req=0, so each instruction is pushed exactly once.
REQ-020 SHALL pop one entry per cycle whenever count != 0; pop uses the pre-push count, so an entry pushed in cycle N reaches the outputs no earlier than the rising edge ending cycle N+1.
REQ-021 SHALL register all trace outputs: on a pop, load the head entry, with debug_wb_rf_wen = {4{entry.wen}}; with no pop, load debug_wb_pc=0, debug_wb_rf_wen=0, debug_wb_rf_wnum=0, debug_wb_rf_wdata=0.
REQ-022 SHALL update count each cycle as count + pushes - pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}; count is $clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH; a 2-entry push writes wptr and wptr+1 (mod DEPTH).
REQ-024 SHALL emit entries in strict program order, never drop an entry, and never duplicate one.

Reset
REQ-025 SHALL, while rst=1 (asynchronous), clear count, rptr, wptr and all trace outputs to 0, which forces stall_req=0; FIFO storage contents need not be cleared.
REQ-026 SHALL, on reset assertion mid-operation, discard all pending entries; the first post-reset output is the first entry pushed after reset.

Structure
REQ-027 SHALL take the trace entry struct type (trace_entry_t) from the shared pipeline package that holds except_bus.
REQ-028 SHALL instantiate exactly one sub-module, fifo_2w1r (a 2-write, 1-read circular buffer parameterised by DEPTH and entry type); stall and output-register logic stay in wb_trace_fifo.

Verification
REQ-029 SHALL verify single retire: master valid, pc=0xBFC00000, wen=1, waddr=3, wdata=0x12 → next cycle debug_wb_pc=0xBFC00000, rf_wen=0xF, wnum=3, wdata=0x12; following cycle all outputs 0.
REQ-030 SHALL verify dual retire: master pc=0x100 (r4) plus slave pc=0x104 (r5) in one cycle → pc 0x100 traced in cycle N+1, pc 0x104 in N+2.
REQ-031 SHALL verify the r0 and no-write cases: master waddr=0 with wen=1 → rf_wen=0x0 while pc is still traced; wen=0 → rf_wen=0x0.
REQ-032 SHALL verify backpressure: DEPTH=8, 7 consecutive dual-valid cycles → stall_req rises once count reaches 7; inputs held during stall are not pushed; all 14 PCs emerge in order with no gaps or duplicates.
REQ-033 SHALL verify slave-only: slave valid alone, pc=0x200 → traced once, with count incremented by exactly 1.
REQ-034 SHALL verify reset mid-stream: rst asserted with count=5 → outputs and stall_req are 0 immediately (asynchronously); after release, a new push of pc=0x300 is the first trace.
